// File: rtl/multicycle_ctrl_if.sv
// Instruction handshake and external ALU bus of the multi-cycle controller.
// The master side issues instructions and supplies the combinational ALU result.
interface multicycle_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
);
  localparam int unsigned RIDX_W  = $clog2(NREGS);
  localparam int unsigned INSTR_W = 3 + 2 * RIDX_W;

  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  imm;
  logic               instr_valid;
  logic               instr_ready;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [1:0]         alu_op;
  logic [DATA_W-1:0]  alu_y;
  logic               alu_zero;

  modport master (
    output instr, imm, instr_valid, alu_y, alu_zero,
    input  instr_ready, alu_a, alu_b, alu_op
  );

  modport slave (
    input  instr, imm, instr_valid, alu_y, alu_zero,
    output instr_ready, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: accepts one instruction at a time, sequences
// decode/exec/write-back around an external ALU and owns the register file.
module multicycle_ctrl #(
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned NREGS   = 4,
  localparam int unsigned RIDX_W  = $clog2(NREGS),
  localparam int unsigned INSTR_W = 3 + 2 * RIDX_W
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.slave   bus,
  output logic               flag_zero,
  output logic               done,
  output logic               halted,
  output logic [2:0]         state_o,
  input  logic [RIDX_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);
  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpLdi  = 3'b101;
  localparam logic [2:0] OpMov  = 3'b110;
  localparam logic [2:0] OpHalt = 3'b111;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StWb     = 3'd3,
    StHalt   = 3'd7
  } state_e;

  state_e state_q, state_d;

  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  imm_q;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [DATA_W-1:0]  alu_a_q, alu_b_q, res_q;
  logic [1:0]         alu_op_q;
  logic               zero_q, flag_zero_q;

  logic [2:0]        opcode, op_m1;
  logic [RIDX_W-1:0] rd, rs;
  logic              is_alu;
  logic [DATA_W-1:0] wb_data;

  assign opcode = instr_q[INSTR_W-1 -: 3];
  assign rd     = instr_q[2*RIDX_W-1 -: RIDX_W];
  assign rs     = instr_q[RIDX_W-1:0];
  assign op_m1  = opcode - 3'd1;
  assign is_alu = (opcode != OpNop) && (opcode < OpLdi);

  always_comb begin
    wb_data = regs_q[rs];
    if (is_alu) begin
      wb_data = res_q;
    end else if (opcode == OpLdi) begin
      wb_data = imm_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.instr_valid) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpNop:        state_d = StIdle;
          OpHalt:       state_d = StHalt;
          OpLdi, OpMov: state_d = StWb;
          default:      state_d = StExec;
        endcase
      end
      StExec:   state_d = StWb;
      StWb:     state_d = StIdle;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q     <= '0;
      imm_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      flag_zero_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            imm_q   <= bus.imm;
          end
        end
        StDecode: begin
          if (is_alu) begin
            alu_a_q  <= regs_q[rd];
            alu_b_q  <= regs_q[rs];
            alu_op_q <= op_m1[1:0];
          end
        end
        StExec: begin
          res_q  <= bus.alu_y;
          zero_q <= bus.alu_zero;
        end
        StWb: begin
          regs_q[rd] <= wb_data;
          // Only ALU ops own the zero flag.
          if (is_alu) flag_zero_q <= zero_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign flag_zero       = flag_zero_q;
  assign done            = (state_q == StWb);
  assign halted          = (state_q == StHalt);
  assign state_o         = state_q;
  assign dbg_data        = regs_q[dbg_sel];
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (DATA_W=8, NREGS=4) with a behavioural ALU.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.DATA_W(8), .NREGS(4)) bus ();

  logic       flag_zero, done, halted;
  logic [2:0] state_o;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;
  logic [7:0] alu_y;

  multicycle_ctrl #(.DATA_W(8), .NREGS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flag_zero (flag_zero),
    .done      (done),
    .halted    (halted),
    .state_o   (state_o),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  always_comb begin
    alu_y = 8'h00;
    case (bus.alu_op)
      2'b00:   alu_y = bus.alu_a + bus.alu_b;
      2'b01:   alu_y = bus.alu_a - bus.alu_b;
      2'b10:   alu_y = bus.alu_a & bus.alu_b;
      default: alu_y = bus.alu_a | bus.alu_b;
    endcase
  end
  assign bus.alu_y    = alu_y;
  assign bus.alu_zero = (alu_y == 8'h00);

  int n_tests = 0;
  int n_fail  = 0;

  int         done_cyc, ndone, bad;
  logic [1:0] exec_op;
  logic [7:0] wb_dbg;
  logic [2:0] st2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_is(input string tag, input logic [1:0] r, input logic [7:0] exp);
    dbg_sel = r;
    #1;
    check(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  // Issue one instruction (accept edge = cycle 0) and observe cycles 1..5.
  task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                     input logic [7:0] imm);
    dbg_sel         = rd;
    bus.instr       = {op, rd, rs};
    bus.imm         = imm;
    bus.instr_valid = 1'b1;
    done_cyc = -1;
    ndone    = 0;
    exec_op  = 2'b00;
    wb_dbg   = 8'h00;
    st2      = 3'd5;
    step();
    bus.instr_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (done) begin
        if (done_cyc < 0) done_cyc = c;
        ndone++;
        wb_dbg = dbg_data;
      end
      if (state_o == 3'd2) exec_op = bus.alu_op;
      if (c == 2) st2 = state_o;
      step();
    end
  endtask

  initial begin
    bus.instr       = '0;
    bus.imm         = '0;
    bus.instr_valid = 1'b0;
    dbg_sel         = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_state", {29'h0, state_o}, 32'd0);
    check("rst_ready", {31'h0, bus.instr_ready}, 32'd1);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_flag", {31'h0, flag_zero}, 32'd0);
    check("rst_halted", {31'h0, halted}, 32'd0);
    check("rst_alu", {22'h0, bus.alu_a, bus.alu_b, bus.alu_op}, 32'd0);
    for (int r = 0; r < 4; r++) reg_is("rst_reg", 2'(r), 8'h00);

    // 1: LDI
    run(3'b101, 2'd1, 2'd0, 8'h05);
    check("ldi1_done_cyc", done_cyc, 2);
    check("ldi1_ndone", ndone, 1);
    run(3'b101, 2'd2, 2'd0, 8'h03);
    check("ldi2_done_cyc", done_cyc, 2);
    reg_is("ldi_r1", 2'd1, 8'h05);
    reg_is("ldi_r2", 2'd2, 8'h03);

    // 2: ADD r1,r2
    run(3'b001, 2'd1, 2'd2, 8'h00);
    check("add_done_cyc", done_cyc, 3);
    check("add_exec_op", {30'h0, exec_op}, 32'd0);
    check("add_wb_old", {24'h0, wb_dbg}, 32'h05);
    reg_is("add_r1", 2'd1, 8'h08);
    check("add_flag", {31'h0, flag_zero}, 32'd0);

    // 3: wrap to zero, then MOV keeps flag
    run(3'b101, 2'd0, 2'd0, 8'hFF);
    run(3'b101, 2'd3, 2'd0, 8'h01);
    run(3'b001, 2'd0, 2'd3, 8'h00);
    reg_is("wrap_r0", 2'd0, 8'h00);
    check("wrap_flag", {31'h0, flag_zero}, 32'd1);
    run(3'b110, 2'd2, 2'd0, 8'h77);
    check("mov_done_cyc", done_cyc, 2);
    reg_is("mov_r2", 2'd2, 8'h00);
    check("mov_flag", {31'h0, flag_zero}, 32'd1);

    // AND / OR / NOP
    run(3'b101, 2'd2, 2'd0, 8'h0C);
    run(3'b011, 2'd1, 2'd2, 8'h00);
    check("and_exec_op", {30'h0, exec_op}, 32'd2);
    reg_is("and_r1", 2'd1, 8'h08);
    check("and_flag", {31'h0, flag_zero}, 32'd0);
    run(3'b100, 2'd0, 2'd2, 8'h00);
    check("or_exec_op", {30'h0, exec_op}, 32'd3);
    reg_is("or_r0", 2'd0, 8'h0C);
    run(3'b000, 2'd3, 2'd3, 8'hAA);
    check("nop_done_cyc", done_cyc, -1);
    check("nop_state_c2", {29'h0, st2}, 32'd0);
    reg_is("nop_r3", 2'd3, 8'h01);

    // SUB with borrow
    run(3'b010, 2'd3, 2'd2, 8'h00);
    check("sub_exec_op", {30'h0, exec_op}, 32'd1);
    reg_is("sub_r3", 2'd3, 8'hF5);
    check("sub_flag", {31'h0, flag_zero}, 32'd0);

    // 4: instr_valid held through SUB r1,r1
    bus.instr       = {3'b010, 2'd1, 2'd1};
    bus.instr_valid = 1'b1;
    bad   = 0;
    ndone = 0;
    step();
    for (int c = 1; c <= 3; c++) begin
      if (bus.instr_ready) bad++;
      if (done) ndone++;
      step();
    end
    check("hold_ready_low", bad, 0);
    check("hold_ready_c4", {31'h0, bus.instr_ready}, 32'd1);
    bus.instr_valid = 1'b0;
    step();
    check("hold_one_accept", {29'h0, state_o}, 32'd0);
    check("hold_ndone", ndone, 1);
    reg_is("hold_r1", 2'd1, 8'h00);
    check("hold_flag", {31'h0, flag_zero}, 32'd1);

    // 5: reset during EXEC of ADD r1,r2
    bus.instr       = {3'b001, 2'd1, 2'd2};
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    check("abort_in_exec", {29'h0, state_o}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("abort_state", {29'h0, state_o}, 32'd0);
    #2 rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) ndone++;
      step();
    end
    check("abort_ndone", ndone, 0);
    check("abort_flag", {31'h0, flag_zero}, 32'd0);
    for (int r = 0; r < 4; r++) reg_is("abort_reg", 2'(r), 8'h00);

    // 6: HALT is sticky
    bus.instr       = {3'b111, 2'd0, 2'd0};
    bus.instr_valid = 1'b1;
    step();
    step();
    bad = 0;
    for (int c = 0; c < 22; c++) begin
      if (!halted || bus.instr_ready || state_o != 3'd7) bad++;
      step();
    end
    check("halt_sticky", bad, 0);
    bus.instr_valid = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    check("halt_rst_state", {29'h0, state_o}, 32'd0);
    check("halt_rst_halted", {31'h0, halted}, 32'd0);
    check("halt_rst_ready", {31'h0, bus.instr_ready}, 32'd1);
    run(3'b101, 2'd2, 2'd0, 8'h5A);
    check("post_ldi_done_cyc", done_cyc, 2);
    reg_is("post_r2", 2'd2, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
